// File: rtl/inst_sram_resp.sv
// Single-cycle instruction SRAM responder with kseg0/kseg1 translation and error tracking.
// Optional macro INST_SRAM_WFIRST_EN selects write-first read data on in-range writes.
module inst_sram_resp #(
    parameter int          DEPTH_LOG2 = 14,
    parameter logic [31:0] BASE_PADDR = 32'h1fc00000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_wen,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    output logic        err_valid,
    output logic [31:0] err_addr,
    output logic [15:0] err_cnt,
    output logic [31:0] rd_cnt
);

    localparam int          DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

`ifdef INST_SRAM_WFIRST_EN
    localparam bit WFIRST = 1'b1;
`else
    localparam bit WFIRST = 1'b0;
`endif

    logic [31:0] mem [DEPTH];

    logic [31:0]           paddr;
    logic [31:0]           offset;
    logic [31:0]           word_off;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  in_range;
    logic                  access;
    logic                  is_write;
    logic [31:0]           old_word;
    logic [31:0]           new_word;
    logic                  unused_ok;

    always_comb begin
        paddr = inst_sram_addr;
        if (inst_sram_addr[31:29] == 3'b100 || inst_sram_addr[31:29] == 3'b101)
            paddr = {3'b000, inst_sram_addr[28:0]};
    end

    // Byte offset below BASE wraps huge, so the lower-bound test is explicit.
    assign offset    = paddr - BASE_PADDR;
    assign word_off  = offset >> 2;
    assign in_range  = (paddr >= BASE_PADDR) && (word_off < DEPTH_W);
    assign idx       = word_off[DEPTH_LOG2-1:0];
    assign unused_ok = ^offset[1:0];

    assign access   = inst_sram_en && !reset;
    assign is_write = inst_sram_wen != 4'h0;
    assign old_word = mem[idx];

    always_comb begin
        new_word = old_word;
        for (int b = 0; b < 4; b++)
            if (inst_sram_wen[b])
                new_word[8*b +: 8] = inst_sram_wdata[8*b +: 8];
    end

    always_ff @(posedge clk) begin
        if (access && in_range && is_write)
            mem[idx] <= new_word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inst_sram_rdata <= 32'h0;
            err_valid       <= 1'b0;
            err_addr        <= 32'h0;
            err_cnt         <= 16'h0;
            rd_cnt          <= 32'h0;
        end else if (inst_sram_en) begin
            if (!in_range) begin
                inst_sram_rdata <= 32'h0;
                if (err_cnt != 16'hffff)
                    err_cnt <= err_cnt + 16'd1;
                if (!err_valid) begin
                    err_valid <= 1'b1;
                    err_addr  <= inst_sram_addr;
                end
            end else if (!is_write) begin
                inst_sram_rdata <= old_word;
                rd_cnt          <= rd_cnt + 32'd1;
            end else begin
                inst_sram_rdata <= WFIRST ? new_word : old_word;
            end
        end
    end

endmodule

// File: tb/tb_inst_sram_resp.sv
// Randomized self-checking bench for inst_sram_resp against a byte-level reference model.
// Honors INST_SRAM_WFIRST_EN the same way as the design build.
module tb_inst_sram_resp;

    localparam int          DEPTH_LOG2 = 14;
    localparam logic [31:0] BASE       = 32'h1fc00000;

`ifdef INST_SRAM_WFIRST_EN
    localparam bit WFIRST = 1'b1;
`else
    localparam bit WFIRST = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        err_valid;
    logic [31:0] err_addr;
    logic [15:0] err_cnt;
    logic [31:0] rd_cnt;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [31:0] m_mem [int unsigned];
    logic [31:0] m_rdata;
    logic        m_err_valid;
    logic [31:0] m_err_addr;
    int          m_err_cnt;
    longint      m_rd_cnt;

    int unsigned filled [$];

    inst_sram_resp #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .BASE_PADDR(BASE)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .inst_sram_en   (inst_sram_en),
        .inst_sram_wen  (inst_sram_wen),
        .inst_sram_addr (inst_sram_addr),
        .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_rdata(inst_sram_rdata),
        .err_valid      (err_valid),
        .err_addr       (err_addr),
        .err_cnt        (err_cnt),
        .rd_cnt         (rd_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] to_paddr(input logic [31:0] va);
        if (va >= 32'ha0000000 && va < 32'hc0000000) return va - 32'ha0000000;
        if (va >= 32'h80000000 && va < 32'ha0000000) return va - 32'h80000000;
        return va;
    endfunction

    function automatic bit in_mem(input logic [31:0] pa);
        longint lo = longint'(BASE);
        longint hi = lo + 4 * (longint'(1) << DEPTH_LOG2);
        return longint'(pa) >= lo && longint'(pa) < hi;
    endfunction

    function automatic void model_step(input logic r, input logic e,
                                       input logic [3:0] w,
                                       input logic [31:0] a,
                                       input logic [31:0] d);
        logic [31:0] pa;
        logic [31:0] old;
        logic [31:0] nw;
        int unsigned ix;
        if (r) begin
            m_rdata = 0; m_err_valid = 0; m_err_addr = 0;
            m_err_cnt = 0; m_rd_cnt = 0;
            return;
        end
        if (!e) return;
        pa = to_paddr(a);
        if (in_mem(pa)) begin
            ix  = (pa - BASE) / 4;
            old = m_mem.exists(ix) ? m_mem[ix] : 32'hx;
            if (w == 4'h0) begin
                m_rdata  = old;
                m_rd_cnt = (m_rd_cnt + 1) % (longint'(1) << 32);
            end else begin
                nw = old;
                for (int b = 0; b < 4; b++)
                    if (w[b]) nw[8*b +: 8] = d[8*b +: 8];
                m_mem[ix] = nw;
                m_rdata = WFIRST ? nw : old;
            end
        end else begin
            m_rdata = 0;
            if (m_err_cnt < 65535) m_err_cnt++;
            if (!m_err_valid) begin
                m_err_valid = 1;
                m_err_addr  = a;
            end
        end
    endfunction

    task automatic drive(input logic r, input logic e, input logic [3:0] w,
                         input logic [31:0] a, input logic [31:0] d);
        reset = r; inst_sram_en = e; inst_sram_wen = w;
        inst_sram_addr = a; inst_sram_wdata = d;
        @(posedge clk);
        model_step(r, e, w, a, d);
        #1;
        reset = 1'b0; inst_sram_en = 1'b0;
    endtask

    function automatic logic [31:0] rand_vaddr(input int unsigned ix);
        logic [31:0] pa = BASE + ix * 4 + $urandom_range(0, 3);
        case ($urandom_range(0, 2))
            0: return pa + 32'h80000000;
            1: return pa + 32'ha0000000;
            default: return pa;
        endcase
    endfunction

    function automatic logic [31:0] rand_oor();
        case ($urandom_range(0, 3))
            0: return 32'hbfc10000 + 4 * $urandom_range(0, 255);
            1: return 32'h1fbffffc;
            2: return 32'hc0000000 | $urandom;
            default: return $urandom & 32'h0fffffff;
        endcase
    endfunction

    task automatic test_reset();
        drive(1, 1, 4'hf, 32'hbfc00000, 32'h12345678);
        checks += 5;
        if (inst_sram_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", inst_sram_rdata); end
        if (err_valid !== 1'b0) begin errors++; $display("FAIL reset_err_valid got %b exp 0", err_valid); end
        if (err_addr !== 32'h0) begin errors++; $display("FAIL reset_err_addr got %h exp 0", err_addr); end
        if (err_cnt !== 16'h0) begin errors++; $display("FAIL reset_err_cnt got %h exp 0", err_cnt); end
        if (rd_cnt !== 32'h0) begin errors++; $display("FAIL reset_rd_cnt got %h exp 0", rd_cnt); end
    endtask

    task automatic test_read();
        drive(0, 1, 4'hf, 32'hbfc00000, 32'h3c1d0000);
        drive(0, 1, 4'h0, 32'hbfc00000, $urandom);
        checks += 2;
        if (inst_sram_rdata !== 32'h3c1d0000) begin errors++; $display("FAIL read_rdata got %h exp 3c1d0000", inst_sram_rdata); end
        if (rd_cnt !== 32'd1) begin errors++; $display("FAIL read_rd_cnt got %0d exp 1", rd_cnt); end
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 4'($urandom), $urandom, $urandom);
            checks++;
            if (inst_sram_rdata !== 32'h3c1d0000) begin errors++; $display("FAIL stall_hold got %h exp 3c1d0000", inst_sram_rdata); end
        end
    endtask

    task automatic test_alias();
        drive(0, 1, 4'hf, 32'h9fc00010, 32'hdeadbeef);
        drive(0, 1, 4'h0, 32'hbfc00010, 0);
        checks++;
        if (inst_sram_rdata !== 32'hdeadbeef) begin errors++; $display("FAIL alias_kseg1 got %h exp deadbeef", inst_sram_rdata); end
        drive(0, 1, 4'h0, 32'h1fc00010, 0);
        checks++;
        if (inst_sram_rdata !== 32'hdeadbeef) begin errors++; $display("FAIL alias_kuseg got %h exp deadbeef", inst_sram_rdata); end
    endtask

    task automatic test_byte_write();
        logic [31:0] wc = WFIRST ? 32'h11bb33dd : 32'h11223344;
        drive(0, 1, 4'hf, 32'hbfc00020, 32'h11223344);
        drive(0, 1, 4'b0101, 32'hbfc00020, 32'haabbccdd);
        checks++;
        if (inst_sram_rdata !== wc) begin errors++; $display("FAIL byte_wr_cycle got %h exp %h", inst_sram_rdata, wc); end
        drive(0, 1, 4'h0, 32'h9fc00022, 0);
        checks++;
        if (inst_sram_rdata !== 32'h11bb33dd) begin errors++; $display("FAIL byte_readback got %h exp 11bb33dd", inst_sram_rdata); end
    endtask

    task automatic test_out_of_range();
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 4'h0, 32'hbfbffffc, 0);
        checks++;
        if (inst_sram_rdata !== 32'h0) begin errors++; $display("FAIL oor1_rdata got %h exp 0", inst_sram_rdata); end
        drive(0, 1, 4'h0, 32'h00000000, 0);
        checks += 5;
        if (inst_sram_rdata !== 32'h0) begin errors++; $display("FAIL oor2_rdata got %h exp 0", inst_sram_rdata); end
        if (err_valid !== 1'b1) begin errors++; $display("FAIL oor_err_valid got %b exp 1", err_valid); end
        if (err_addr !== 32'hbfbffffc) begin errors++; $display("FAIL oor_err_addr got %h exp bfbffffc", err_addr); end
        if (err_cnt !== 16'd2) begin errors++; $display("FAIL oor_err_cnt got %0d exp 2", err_cnt); end
        if (rd_cnt !== 32'd0) begin errors++; $display("FAIL oor_rd_cnt got %0d exp 0", rd_cnt); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 32; i++) begin
            filled.push_back(i);
            filled.push_back((1 << DEPTH_LOG2) - 1 - i);
        end
        foreach (filled[k])
            drive(0, 1, 4'hf, rand_vaddr(filled[k]), $urandom);
        for (int i = 0; i < 300; i++) begin
            int unsigned ix = filled[$urandom_range(0, filled.size() - 1)];
            int kind = $urandom_range(0, 9);
            if (kind < 5)      drive(0, 1, 4'h0, rand_vaddr(ix), $urandom);
            else if (kind < 7) drive(0, 1, 4'($urandom_range(1, 15)), rand_vaddr(ix), $urandom);
            else if (kind < 9) drive(0, 1, 4'($urandom), rand_oor(), $urandom);
            else               drive(0, 0, 4'($urandom), $urandom, $urandom);
            checks += 5;
            if (inst_sram_rdata !== m_rdata) begin errors++; $display("FAIL rnd_rdata @%0d got %h exp %h", i, inst_sram_rdata, m_rdata); end
            if (err_valid !== m_err_valid) begin errors++; $display("FAIL rnd_err_valid @%0d got %b exp %b", i, err_valid, m_err_valid); end
            if (err_addr !== m_err_addr) begin errors++; $display("FAIL rnd_err_addr @%0d got %h exp %h", i, err_addr, m_err_addr); end
            if (err_cnt !== 16'(m_err_cnt)) begin errors++; $display("FAIL rnd_err_cnt @%0d got %0d exp %0d", i, err_cnt, m_err_cnt); end
            if (rd_cnt !== 32'(m_rd_cnt)) begin errors++; $display("FAIL rnd_rd_cnt @%0d got %0d exp %0d", i, rd_cnt, m_rd_cnt); end
        end
    endtask

    task automatic test_back_to_back_reset();
        logic [31:0] a6 = 0;
        for (int i = 0; i < 10; i++) begin
            logic [31:0] a = rand_vaddr(filled[$urandom_range(0, filled.size() - 1)]);
            if (i == 5) begin
                a6 = a;
                drive(1, 1, 4'hf, a, ~m_mem[(to_paddr(a) - BASE) / 4]);
                checks += 4;
                if (inst_sram_rdata !== 32'h0) begin errors++; $display("FAIL b2b_rst_rdata got %h exp 0", inst_sram_rdata); end
                if (err_valid !== 1'b0) begin errors++; $display("FAIL b2b_rst_err_valid got %b exp 0", err_valid); end
                if (err_cnt !== 16'h0) begin errors++; $display("FAIL b2b_rst_err_cnt got %0d exp 0", err_cnt); end
                if (rd_cnt !== 32'h0) begin errors++; $display("FAIL b2b_rst_rd_cnt got %0d exp 0", rd_cnt); end
            end else begin
                drive(0, 1, 4'h0, a, 0);
                checks += 2;
                if (inst_sram_rdata !== m_rdata) begin errors++; $display("FAIL b2b_rdata @%0d got %h exp %h", i, inst_sram_rdata, m_rdata); end
                if (rd_cnt !== 32'(m_rd_cnt)) begin errors++; $display("FAIL b2b_rd_cnt @%0d got %0d exp %0d", i, rd_cnt, m_rd_cnt); end
            end
        end
        drive(0, 1, 4'h0, a6, 0);
        checks++;
        if (inst_sram_rdata !== m_rdata) begin errors++; $display("FAIL b2b_mem_kept got %h exp %h", inst_sram_rdata, m_rdata); end
    endtask

    task automatic test_saturation();
        logic [31:0] first = 32'hc0000000 | $urandom;
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 4'h0, first, 0);
        for (int i = 1; i < 65534; i++)
            drive(0, 1, 4'($urandom), rand_oor(), $urandom);
        checks++;
        if (err_cnt !== 16'hfffe) begin errors++; $display("FAIL sat_pre got %h exp fffe", err_cnt); end
        for (int i = 0; i < 3; i++)
            drive(0, 1, 4'($urandom), rand_oor(), $urandom);
        checks += 4;
        if (err_cnt !== 16'hffff) begin errors++; $display("FAIL sat_cnt got %h exp ffff", err_cnt); end
        if (err_addr !== first) begin errors++; $display("FAIL sat_err_addr got %h exp %h", err_addr, first); end
        if (err_valid !== 1'b1) begin errors++; $display("FAIL sat_err_valid got %b exp 1", err_valid); end
        if (rd_cnt !== 32'h0) begin errors++; $display("FAIL sat_rd_cnt got %0d exp 0", rd_cnt); end
    endtask

    initial begin
        reset = 1'b1; inst_sram_en = 1'b0; inst_sram_wen = 4'h0;
        inst_sram_addr = 32'h0; inst_sram_wdata = 32'h0;
        m_rdata = 0; m_err_valid = 0; m_err_addr = 0; m_err_cnt = 0; m_rd_cnt = 0;
        @(posedge clk); #1;
        test_reset();
        test_read();
        test_alias();
        test_byte_write();
        test_out_of_range();
        test_random();
        test_back_to_back_reset();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
